// File: rtl/mux_sel_arb_pkg.sv
// Shared types and constants for the 4-channel round-robin select arbiter.
package mux_sel_arb_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Channel index to one-hot request/acknowledge vector.
  function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_sel_arb_rr_pick.sv
// Rotating-priority picker: first set request bit at or after base, mod NCH.
module rr_pick
  import mux_sel_arb_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Scan from lowest priority to highest so the highest-priority hit is written last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    idx  = base;
    any  = 1'b0;
    cand = base;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = base + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arb.sv
// Round-robin arbiter driving a 4:1 mux select with valid/ready handshake,
// back-to-back grants and a stall timeout that abandons a stuck grant.
module mux_sel_arb
  import mux_sel_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   req_ack,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic             timeout_err,
  input  logic             clr_err
);

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             handshake;
  logic             timeout_fire;
  logic [SEL_W-1:0] sel_next;
  logic [NCH-1:0]   pick_req;
  logic [SEL_W-1:0] pick_base;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  assign sel_valid   = (state_q == GRANT);
  assign sel         = sel_q;
  assign timeout_err = err_q;
  assign handshake   = sel_valid & sel_ready;
  assign req_ack     = onehot(sel_q) & {NCH{handshake}};
  assign sel_next    = sel_q + 1'b1;

  // One picker serves both paths: fresh arbitration from ptr in IDLE, and the
  // back-to-back follow-on grant (current channel masked out) in GRANT.
  always_comb begin
    if (state_q == GRANT) begin
      pick_req  = req & ~onehot(sel_q);
      pick_base = sel_next;
    end else begin
      pick_req  = req;
      pick_base = ptr_q;
    end
  end

  rr_pick u_rr_pick (
    .req  (pick_req),
    .base (pick_base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next-state logic: grant, handshake/re-grant, stall counting and timeout.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (sel_ready) begin
          // A ready in the last stall cycle still completes normally.
          ptr_d = sel_next;
          cnt_d = '0;
          if (pick_any) sel_d   = pick_idx;
          else          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = IDLE;
          ptr_d        = sel_next;
          timeout_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new timeout outranks a simultaneous clear.
    if (timeout_fire) err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
  end

  // State registers; reset abandons any grant without flagging an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_arb.sv
// Self-checking bench for mux_sel_arb (TIMEOUT=3): behavioural model compared
// every cycle plus directed literal expectations.
module tb_mux_sel_arb;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] req_ack;
  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_ready = 1'b0;
  logic       timeout_err;
  logic       clr_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mux_sel_arb #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_ack     (req_ack),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .sel_ready   (sel_ready),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Channel list in priority order starting at base; first requester wins.
  function automatic int pick(input int r, input int base);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (base + k) % 4;
      if (((r >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  bit m_busy   = 0;
  int m_sel    = 0;
  int m_ptr    = 0;
  int m_stalls = 0;  // stalled cycles already spent on the live grant
  bit m_err    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_stalls = 0; m_err = 0;
    end else begin
      bit abandon;
      int nxt;
      abandon = 0;
      if (m_busy) begin
        if (sel_ready) begin
          m_ptr = (m_sel + 1) % 4;
          nxt   = pick(int'(req) & ~(1 << m_sel), m_ptr);
          if (nxt >= 0) begin m_sel = nxt; m_stalls = 0; end
          else m_busy = 0;
        end else if (m_stalls + 1 == TO) begin
          m_busy  = 0;
          abandon = 1;
          m_ptr   = (m_sel + 1) % 4;
        end else begin
          m_stalls++;
        end
      end else begin
        nxt = pick(int'(req), m_ptr);
        if (nxt >= 0) begin m_busy = 1; m_sel = nxt; m_stalls = 0; end
      end
      if (abandon) m_err = 1;
      else if (clr_err) m_err = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_sel_valid", 32'(sel_valid), 32'(m_busy));
      check("model_sel", 32'(sel), 32'(m_sel));
      check("model_req_ack", 32'(req_ack), (m_busy && sel_ready) ? (32'd1 << m_sel) : 32'd0);
      check("model_timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [3:0] r, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    req = r; sel_ready = rdy; clr_err = clr;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    req = 4'b0; sel_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_sel_valid", 32'(sel_valid), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_req_ack", 32'(req_ack), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    #1 rst_n = 1'b1;

    // Single requester 2, latency 1, ack in the grant cycle; ptr moves to 3.
    tick(4'b0100, 1, 0);
    check("lat_idle", 32'(sel_valid), 0);
    tick(4'b0100, 1, 0);
    check("g2_valid", 32'(sel_valid), 1);
    check("g2_sel", 32'(sel), 2);
    check("g2_ack", 32'(req_ack), 32'b0100);
    tick(4'b0000, 1, 0);
    check("g2_done", 32'(sel_valid), 0);
    tick(4'b1001, 1, 0);
    tick(4'b0000, 1, 0);
    check("ptr3_sel", 32'(sel), 3);
    check("ptr3_ack", 32'(req_ack), 32'b1000);

    // All four requesting from reset: 0,1,2,3,0 with no bubble.
    pulse_reset();
    tick(4'b1111, 1, 0);
    check("rr_lat", 32'(sel_valid), 0);
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111, 1, 0);
      check($sformatf("rr_valid_%0d", i), 32'(sel_valid), 1);
      check($sformatf("rr_sel_%0d", i), 32'(sel), 32'(i % 4));
      check($sformatf("rr_ack_%0d", i), 32'(req_ack), 32'd1 << (i % 4));
    end
    tick(4'b0000, 1, 0);
    check("rr_sel_tail", 32'(sel), 1);
    tick(4'b0000, 1, 0);
    check("rr_idle", 32'(sel_valid), 0);

    // Wrap-around grant to channel 0 from ptr=1, then ptr stays at 1.
    tick(4'b0001, 1, 0);
    tick(4'b0001, 1, 0);
    check("w_first_sel", 32'(sel), 0);
    tick(4'b0001, 1, 0);
    check("w_bubble", 32'(sel_valid), 0);
    tick(4'b0001, 1, 0);
    check("wrap_valid", 32'(sel_valid), 1);
    check("wrap_sel", 32'(sel), 0);
    check("wrap_ack", 32'(req_ack), 32'b0001);
    tick(4'b0000, 1, 0);
    tick(4'b0011, 1, 0);
    tick(4'b0000, 1, 0);
    check("ptr1_sel", 32'(sel), 1);
    tick(4'b0000, 0, 0);

    // Timeout: exactly 3 valid cycles, no ack, sticky error, ptr -> 2.
    tick(4'b0010, 0, 0);
    check("to_pre", 32'(sel_valid), 0);
    tick(4'b0010, 0, 0);
    check("to_v1", 32'(sel_valid), 1);
    check("to_sel", 32'(sel), 1);
    tick(4'b0010, 0, 0);
    check("to_v2", 32'(sel_valid), 1);
    tick(4'b0000, 0, 0);
    check("to_v3", 32'(sel_valid), 1);
    check("to_noack", 32'(req_ack), 0);
    tick(4'b0000, 0, 0);
    check("to_drop", 32'(sel_valid), 0);
    check("to_err", 32'(timeout_err), 1);

    // ptr=2 check, then a second timeout coinciding with clr_err: set wins.
    tick(4'b0110, 0, 0);
    tick(4'b0000, 0, 0);
    check("ptr2_sel", 32'(sel), 2);
    tick(4'b0000, 0, 0);
    tick(4'b0000, 0, 1);
    tick(4'b0000, 1, 0);
    check("coinc_drop", 32'(sel_valid), 0);
    check("coinc_err", 32'(timeout_err), 1);
    check("idle_ready_noack", 32'(req_ack), 0);
    tick(4'b0000, 1, 1);
    check("clr_pending", 32'(timeout_err), 1);
    tick(4'b0000, 0, 0);
    check("clr_done", 32'(timeout_err), 0);

    // Reset mid-grant on channel 3 (ptr is 3 here), then fresh grant to 3.
    tick(4'b1000, 0, 0);
    tick(4'b0000, 0, 0);
    check("mid_sel", 32'(sel), 3);
    check("mid_valid", 32'(sel_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(sel_valid), 0);
    check("mid_rst_sel", 32'(sel), 0);
    check("mid_rst_ack", 32'(req_ack), 0);
    check("mid_rst_err", 32'(timeout_err), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick(4'b1000, 1, 0);
    tick(4'b0000, 1, 0);
    check("post_rst_sel", 32'(sel), 3);
    check("post_rst_ack", 32'(req_ack), 32'b1000);
    tick(4'b0000, 0, 0);
    check("post_rst_idle", 32'(sel_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
